// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared definitions for the sequential seven-segment display driver:
//   - state_e    : controller FSM states (IDLE, CONVERT, LOAD)
//   - SEG_*      : active-low glyphs, bit 0 = segment a ... bit 6 = segment g
//   - pow10()    : constant function used for the display range checks
// -----------------------------------------------------------------------------
package display_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    LOAD    = 2'd2
  } state_e;

  localparam int GLYPH_W = 7;

  localparam logic [GLYPH_W-1:0] SEG_BLANK = 7'h7F;  // all segments off
  localparam logic [GLYPH_W-1:0] SEG_MINUS = 7'h3F;  // only g lit

  // Index n holds the glyph for decimal digit n (active-low, gfedcba).
  localparam logic [9:0][GLYPH_W-1:0] SEG_DIGITS = {
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/seg7_encoder.sv
// -----------------------------------------------------------------------------
// seg7_encoder
// Maps one BCD digit plus blank/minus overrides to active-low segments.
// Minus has priority over blank; codes above 9 render as blank.
// Ports:
//   digit  in  4         BCD digit 0..9
//   blank  in  1         force all segments off
//   minus  in  1         show only segment g
//   seg    out SEGMENTS  active-low segments, bit 0 = a; bits above g stay off
// -----------------------------------------------------------------------------
module seg7_encoder
  import display_pkg::*;
#(
  parameter int SEGMENTS = 7
) (
  input  logic [3:0]          digit,
  input  logic                blank,
  input  logic                minus,
  output logic [SEGMENTS-1:0] seg
);

  logic [GLYPH_W-1:0] glyph;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    glyph = SEG_BLANK;
    if (minus) begin
      glyph = SEG_MINUS;
    end else if (!blank && (digit <= 4'd9)) begin
      glyph = SEG_DIGITS[digit];
    end
  end

  for (genvar i = 0; i < SEGMENTS; i++) begin : g_seg
    if (i < GLYPH_W) begin : g_glyph
      assign seg[i] = glyph[i];
    end else begin : g_pad
      assign seg[i] = 1'b1;
    end
  end

endmodule

// File: rtl/seq_display_driver.sv
// -----------------------------------------------------------------------------
// seq_display_driver
// Accepts a binary value over a valid/ready handshake, converts it to BCD with
// a bit-serial double dabble (one bit per cycle), and drives DIGITS
// seven-segment digits with leading-zero blanking, a minus sign for negative
// values and an all-minus pattern when the value does not fit.
// Accept at edge T -> hex/overflow update and done pulses after edge
// T+BIT_SIZE+1.
//
// Optional feature macro: DISPLAY_BLINK_EN
//   defined   : overflow pattern blinks minus/blank every 2^BLINK_DIV cycles
//   undefined : overflow pattern is steady, no blink counter is built
//
// Ports:
//   clk        in   1                single clock, rising edge
//   rst_n      in   1                asynchronous active-low reset
//   in_valid   in   1                request to display number
//   in_ready   out  1                high only in IDLE
//   number     in   BIT_SIZE         value to display
//   is_signed  in   1                number is two's complement
//   hex        out  DIGITS*SEGMENTS  digit k at [k*SEGMENTS +: SEGMENTS], active-low
//   done       out  1                one-cycle pulse when hex takes a new value
//   overflow   out  1                last accepted value does not fit
// -----------------------------------------------------------------------------
module seq_display_driver
  import display_pkg::*;
#(
  parameter int SEGMENTS  = 7,
  parameter int BIT_SIZE  = 20,
  parameter int DIGITS    = 6,
  parameter int BLINK_DIV = 24
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [BIT_SIZE-1:0]          number,
  input  logic                         is_signed,
  output logic [DIGITS*SEGMENTS-1:0]   hex,
  output logic                         done,
  output logic                         overflow
);

  localparam int BCD_W = DIGITS * 4;
  localparam int HEX_W = DIGITS * SEGMENTS;
  localparam int CNT_W = (BIT_SIZE > 1) ? $clog2(BIT_SIZE) : 1;

  if ((DIGITS < 2) || (DIGITS > 8)) begin : g_bad_digits
    $error("seq_display_driver: DIGITS must be 2..8");
  end
  if (BLINK_DIV < 1) begin : g_bad_blink
    $error("seq_display_driver: BLINK_DIV must be at least 1");
  end

  state_e              state, state_next;
  logic [BIT_SIZE-1:0] mag_sh;     // magnitude, shifted out MSB first
  logic [BCD_W-1:0]    bcd;
  logic [CNT_W-1:0]    cnt;
  logic                neg_r;
  logic                ovf_r;      // range result computed at accept time
  logic [HEX_W-1:0]    hex_r;
  logic                done_r;
  logic                overflow_r;

  // ---------------------------------------------------------------------------
  // Capture-side arithmetic
  // ---------------------------------------------------------------------------
  logic                neg_in;
  logic [BIT_SIZE-1:0] mag_in;
  logic [63:0]         mag_ext;
  logic                ovf_in;

  // Negating in BIT_SIZE unsigned bits maps -2^(BIT_SIZE-1) onto
  // 2^(BIT_SIZE-1) without wrapping.
  assign neg_in  = is_signed & number[BIT_SIZE-1];
  assign mag_in  = neg_in ? ((~number) + BIT_SIZE'(1)) : number;
  assign mag_ext = 64'(mag_in);
  // A negative value needs one digit for the sign, so its range is a decade
  // smaller.
  assign ovf_in  = (mag_ext >= pow10(DIGITS)) ||
                   (neg_in && (mag_ext >= pow10(DIGITS - 1)));

  // ---------------------------------------------------------------------------
  // Double dabble step: add 3 to any digit >= 5, then shift in the next bit.
  // When the value overflows the BCD register the top bits are simply lost;
  // the display then shows the overflow pattern anyway.
  // ---------------------------------------------------------------------------
  logic [BCD_W-1:0] bcd_adj;
  logic [BCD_W-1:0] bcd_shift;

  always_comb begin
    bcd_adj = bcd;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd[k*4 +: 4] >= 4'd5) bcd_adj[k*4 +: 4] = bcd[k*4 +: 4] + 4'd3;
    end
  end

  assign bcd_shift = {bcd_adj[BCD_W-2:0], mag_sh[BIT_SIZE-1]};

  // ---------------------------------------------------------------------------
  // Glyph selection from the finished BCD value
  // ---------------------------------------------------------------------------
  int                msd;        // most significant non-zero digit, 0 for zero
  logic [DIGITS-1:0] blank_d;
  logic [DIGITS-1:0] minus_d;
  logic [HEX_W-1:0]  seg_pattern;

  always_comb begin
    msd = 0;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd[k*4 +: 4] != 4'd0) msd = k;
    end
    blank_d = '0;
    minus_d = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (ovf_r) begin
        minus_d[k] = 1'b1;
      end else if (k > msd) begin
        if (neg_r && (k == msd + 1)) minus_d[k] = 1'b1;
        else                         blank_d[k] = 1'b1;
      end
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    seg7_encoder #(
      .SEGMENTS(SEGMENTS)
    ) u_enc (
      .digit(bcd[k*4 +: 4]),
      .blank(blank_d[k]),
      .minus(minus_d[k]),
      .seg  (seg_pattern[k*SEGMENTS +: SEGMENTS])
    );
  end

  // ---------------------------------------------------------------------------
  // Controller FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = CONVERT;
      CONVERT: if (cnt == CNT_W'(BIT_SIZE - 1)) state_next = LOAD;
      LOAD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_sh     <= '0;
      bcd        <= '0;
      cnt        <= '0;
      neg_r      <= 1'b0;
      ovf_r      <= 1'b0;
      hex_r      <= '1;
      done_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            mag_sh <= mag_in;
            neg_r  <= neg_in;
            ovf_r  <= ovf_in;
            bcd    <= '0;
            cnt    <= '0;
          end
        end
        CONVERT: begin
          bcd    <= bcd_shift;
          mag_sh <= mag_sh << 1;
          cnt    <= cnt + CNT_W'(1);
        end
        LOAD: begin
          // hex only changes here, so intermediate BCD values never reach it.
          hex_r      <= seg_pattern;
          overflow_r <= ovf_r;
          done_r     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready = (state == IDLE);
  assign done     = done_r;
  assign overflow = overflow_r;

`ifdef DISPLAY_BLINK_EN
  logic [BLINK_DIV:0] blink_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blink_cnt <= '0;
    else        blink_cnt <= blink_cnt + (BLINK_DIV + 1)'(1);
  end

  // Top counter bit flips every 2^BLINK_DIV cycles; blank during its high half.
  assign hex = (overflow_r && blink_cnt[BLINK_DIV]) ? {HEX_W{1'b1}} : hex_r;
`else
  assign hex = hex_r;
`endif

endmodule

// File: doc/seq_display_driver.md
SEQ_DISPLAY_DRIVER -- requirements
Module: seq_display_driver

Interface
REQ-001 Parameter SEGMENTS, default 7: segments per digit.
REQ-002 Parameter BIT_SIZE, default 20: input value width.
REQ-003 Parameter DIGITS, default 6: number of seven-segment digits, 2..8.
REQ-004 Parameter BLINK_DIV, default 24: overflow blink half-period is 2^BLINK_DIV cycles.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 in_valid  in  1  request to display a new value.
REQ-008 in_ready  out  1  block can accept a value.
REQ-009 number  in  BIT_SIZE  value to display.
REQ-010 is_signed  in  1  1 = treat number as two's complement.
REQ-011 hex  out  DIGITS*SEGMENTS  segments of digit k at [k*SEGMENTS +: SEGMENTS], bit 0 = a ... bit 6 = g, active-low, digit 0 = units.
REQ-012 done  out  1  one-cycle pulse when hex takes a new value.
REQ-013 overflow  out  1  last accepted value does not fit the display.

Function
REQ-014 FSM states: IDLE, CONVERT, LOAD; in_ready SHALL be 1 only in IDLE.
REQ-015 Transfer occurs when in_valid && in_ready; number, is_signed, and the sign flag SHALL be captured and IDLE->CONVERT taken.
REQ-016 in_valid outside IDLE SHALL be ignored; no queueing.
REQ-017 Magnitude SHALL be computed as a BIT_SIZE-bit unsigned value; -2^(BIT_SIZE-1) SHALL yield 2^(BIT_SIZE-1) without wrap.
REQ-018 CONVERT SHALL run shift-add-3 (double dabble) on a DIGITS*4-bit BCD register, one bit per cycle, exactly BIT_SIZE cycles, then go to LOAD.
REQ-019 LOAD SHALL last one cycle, register hex, overflow and done=1, then return to IDLE; accept at edge T, hex valid after edge T+BIT_SIZE+1.
REQ-020 Overflow SHALL be set when magnitude >= 10^DIGITS, or when negative and magnitude >= 10^(DIGITS-1).
REQ-021 Leading-zero digits above the most significant non-zero digit SHALL be blank (all segments 1); digit 0 SHALL always show a digit; value 0 shows "0".
REQ-022 Negative values SHALL show a minus (only g lit) in the digit immediately above the most significant non-zero digit.
REQ-023 On overflow every digit SHALL show minus.
REQ-024 hex SHALL hold its value between LOAD cycles; no glitches during CONVERT.

Reset
REQ-025 While rst_n=0: state IDLE, hex all ones (blank), done=0, overflow=0, in_ready=1 after release.
REQ-026 Reset mid-CONVERT SHALL abort the conversion; no done pulse, the value is lost.

Configuration
REQ-027 With DISPLAY_BLINK_EN defined, the overflow pattern SHALL alternate minus/blank every 2^BLINK_DIV cycles via a free-running counter cleared by reset.
REQ-028 Without DISPLAY_BLINK_EN, the overflow pattern SHALL be steady and the counter SHALL not exist.

Structure
REQ-029 Package display_pkg SHALL hold the FSM state enum, glyph constants (BLANK, MINUS, digit codes 0-9), and a pow10 constant function.
REQ-030 One sub-module, seg7_encoder, SHALL map a 4-bit digit plus blank/minus flags to SEGMENTS active-low outputs; DIGITS instances.

Verification (DIGITS=6, BIT_SIZE=20)
REQ-031 Send number=0, is_signed=0 -> done 21 cycles after accept; digit0 "0", digits 1-5 blank, overflow=0.
REQ-032 Send 999999 unsigned -> all six digits "999999", overflow=0; then send 20'hFFFFF unsigned (1048575) -> all digits minus, overflow=1.
REQ-033 Send -45 signed -> digit0 "5", digit1 "4", digit2 minus, digits 3-5 blank.
REQ-034 Send -524288 signed -> overflow=1, all minus; with DISPLAY_BLINK_EN and BLINK_DIV=4, hex toggles minus/blank every 16 cycles.
REQ-035 Hold in_valid for 50 cycles with 123 then 456 -> 123 accepted; in_ready=0 for 21 cycles; 456 accepted on the first IDLE cycle; exactly two done pulses.
REQ-036 Assert rst_n=0 at cycle 10 of a conversion -> hex blank, no done; after release, in_ready=1 and the next transfer completes normally.
